// File: rtl/pcpi_pkg.sv
// Shared types and helpers for the PCPI coprocessor hub.
package pcpi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  localparam int XLEN_DEF       = 32;
  localparam int WDOG_LIMIT_DEF = 200;

  // Channel index width; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcpi_prio_sel.sv
// Lowest-index priority encoder with any/multi-hot detect.
module pcpi_prio_sel
  import pcpi_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  output logic [CH_W-1:0] idx,
  output logic            any,
  output logic            multi
);

  // Scan high to low so the lowest set bit is written last and wins.
  always_comb begin
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = CH_W'(i);
    end
  end

  assign any   = |req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(req & (req - N_CH'(1)));

endmodule

// File: rtl/pcpi_hub.sv
// N-channel PCPI hub: sequenced request/response between core and coprocessors.
module pcpi_hub
  import pcpi_pkg::*;
#(
  parameter  int N_CH       = 4,
  parameter  int XLEN       = XLEN_DEF,
  parameter  int WDOG_W     = 8,
  parameter  int WDOG_LIMIT = WDOG_LIMIT_DEF,
  localparam int CH_W       = ch_w(N_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pcpi_valid,
  input  logic [XLEN-1:0]      pcpi_insn,
  input  logic [XLEN-1:0]      pcpi_rs1,
  input  logic [XLEN-1:0]      pcpi_rs2,
  output logic                 pcpi_wr,
  output logic [XLEN-1:0]      pcpi_rd,
  output logic                 pcpi_wait,
  output logic                 pcpi_ready,
  input  logic [N_CH-1:0]      ch_en,
  output logic [N_CH-1:0]      ch_valid,
  output logic [XLEN-1:0]      ch_insn,
  output logic [XLEN-1:0]      ch_rs1,
  output logic [XLEN-1:0]      ch_rs2,
  input  logic [N_CH-1:0]      ch_wr,
  input  logic [N_CH*XLEN-1:0] ch_rd,
  input  logic [N_CH-1:0]      ch_wait,
  input  logic [N_CH-1:0]      ch_ready,
  input  logic                 status_clr,
  output logic                 err_collision,
  output logic                 err_timeout,
  output logic [CH_W-1:0]      last_ch,
  output logic                 busy
);

  localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(WDOG_LIMIT - 1);
  localparam logic [WDOG_W-1:0] WD_SAT  = WDOG_W'(WDOG_LIMIT);

  state_e                      state_q, state_d;
  logic                        wr_q, wr_d;
  logic [XLEN-1:0]             rd_q, rd_d;
  logic [CH_W-1:0]             last_q, last_d;
  logic [WDOG_W-1:0]           wdog_q, wdog_d;
  logic                        claimed_q, claimed_d;
  logic                        col_q, col_d;
  logic                        to_q, to_d;
  logic                        set_col, set_to;

  logic [N_CH-1:0][XLEN-1:0]   ch_rd_a;
  logic [N_CH-1:0]             rdy_m;
  logic                        claim_now;
  logic [CH_W-1:0]             sel_idx;
  logic                        sel_any, sel_multi;

  assign ch_rd_a   = ch_rd;
  assign rdy_m     = ch_ready & ch_en;
  assign claim_now = |(ch_wait & ch_en);

  pcpi_prio_sel #(.N_CH(N_CH)) u_sel (
    .req   (rdy_m),
    .idx   (sel_idx),
    .any   (sel_any),
    .multi (sel_multi)
  );

  // Operands are broadcast unregistered; only ACTIVE lets a request through.
  assign ch_insn       = pcpi_insn;
  assign ch_rs1        = pcpi_rs1;
  assign ch_rs2        = pcpi_rs2;
  assign ch_valid      = {N_CH{pcpi_valid && (state_q == ACTIVE)}} & ch_en;
  assign pcpi_wait     = (state_q == ACTIVE) && claim_now;
  assign pcpi_ready    = (state_q == RESP);
  assign pcpi_wr       = wr_q;
  assign pcpi_rd       = rd_q;
  assign last_ch       = last_q;
  assign err_collision = col_q;
  assign err_timeout   = to_q;
  assign busy          = (state_q != IDLE);

  // Transaction sequencing, response capture and watchdog.
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    claimed_d = claimed_q;
    set_col   = 1'b0;
    set_to    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pcpi_valid) begin
          state_d   = ACTIVE;
          wdog_d    = '0;
          claimed_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (sel_any) begin
          wr_d    = ch_wr[sel_idx];
          rd_d    = ch_rd_a[sel_idx];
          last_d  = sel_idx;
          set_col = sel_multi;
          state_d = RESP;
        end else if (claimed_q && (wdog_q == WD_LAST)) begin
          wr_d    = 1'b0;
          rd_d    = '0;
          set_to  = 1'b1;
          state_d = RESP;
        end else if (!pcpi_valid) begin
          state_d = IDLE;
        end else begin
          claimed_d = claimed_q | claim_now;
          // Counting starts in the first claim cycle so expiry lands LIMIT cycles later.
          if (claimed_d && (wdog_q != WD_SAT)) wdog_d = wdog_q + 1'b1;
        end
      end
      RESP: begin
        wr_d    = 1'b0;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (!pcpi_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    col_d = (col_q & ~status_clr) | set_col;
    to_d  = (to_q & ~status_clr) | set_to;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      rd_q      <= '0;
      last_q    <= '0;
      wdog_q    <= '0;
      claimed_q <= 1'b0;
      col_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      claimed_q <= claimed_d;
      col_q     <= col_d;
      to_q      <= to_d;
    end
  end

endmodule

// File: doc/pcpi_hub.md
Name: pcpi_hub

Overview:
- Parametrised N-channel PCPI arbiter/response hub between the picorv32 core and its coprocessors (picorv32 mul/div, exact mul, approx mul, future accelerators).
- Replaces the fixed 4-way combinational OR/priority mux with a sequenced transaction FSM that provides:
  - registered response
  - per-channel enable mask
  - valid gating after completion
  - claim watchdog
  - sticky collision/timeout status

Parameters:
- N_CH, 4, number of coprocessor channels (1..16)
- XLEN, 32, data width of insn/rs1/rs2/rd
- WDOG_W, 8, watchdog counter width
- WDOG_LIMIT, 200, cycles a claimed op may run before forced completion (must be < 2**WDOG_W)
- Derived localparam CH_W = max(1, clog2(N_CH))

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pcpi_valid  in  1  core request valid
- pcpi_insn  in  XLEN  core instruction word
- pcpi_rs1  in  XLEN  operand 1
- pcpi_rs2  in  XLEN  operand 2
- pcpi_wr  out  1  response writes rd
- pcpi_rd  out  XLEN  response data
- pcpi_wait  out  1  some enabled channel has claimed the op
- pcpi_ready  out  1  response valid to core (1-cycle pulse)
- ch_en  in  N_CH  channel enable mask
- ch_valid  out  N_CH  per-channel request valid
- ch_insn  out  XLEN  broadcast instruction
- ch_rs1  out  XLEN  broadcast operand 1
- ch_rs2  out  XLEN  broadcast operand 2
- ch_wr  in  N_CH  per-channel write flag
- ch_rd  in  N_CH*XLEN  per-channel result; channel i at [i*XLEN +: XLEN]
- ch_wait  in  N_CH  per-channel claim
- ch_ready  in  N_CH  per-channel done
- status_clr  in  1  clears sticky flags
- err_collision  out  1  sticky: more than one enabled ch_ready in the same cycle
- err_timeout  out  1  sticky: watchdog fired
- last_ch  out  CH_W  index of last completing channel
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - state = IDLE
  - all outputs 0
  - pcpi_rd = 0, last_ch = 0, watchdog = 0, claimed = 0
- ch_insn/ch_rs1/ch_rs2 are combinational pass-through of the core inputs.
- ch_valid = {N_CH{pcpi_valid && state==ACTIVE}} & ch_en. In IDLE, RESP and DRAIN, ch_valid = 0.
- pcpi_wait = (state==ACTIVE) && |(ch_wait & ch_en). Combinational, so the core's 16-cycle illegal-insn timeout behaves exactly as with a direct connection.
- FSM:
  - IDLE:
    - pcpi_valid=1 → ACTIVE; clear watchdog and claimed.
  - ACTIVE:
    - If r = ch_ready & ch_en is nonzero:
      - latch wr/rd of the lowest set index into the output regs; last_ch ← index
      - if popcount(r) > 1, set err_collision
      - → RESP
    - Else if claimed and watchdog == WDOG_LIMIT-1:
      - pcpi_wr ← 0, pcpi_rd ← 0; set err_timeout
      - → RESP
    - Else if pcpi_valid=0 (core aborted / illegal insn) → IDLE, with no response.
    - Otherwise:
      - claimed ← claimed | |(ch_wait & ch_en)
      - watchdog increments while claimed and saturates at the limit.
  - RESP:
    - pcpi_ready=1 for exactly one cycle; pcpi_wr/pcpi_rd hold the latched values → DRAIN.
    - Latency: channel ready at cycle t → core ready at t+1.
  - DRAIN:
    - pcpi_ready=0; ch_valid held at 0 so channels cannot restart.
    - pcpi_valid=0 → IDLE; otherwise stay.
- pcpi_wr is asserted only during the RESP cycle. pcpi_rd retains its last value (don't-care to the core).
- Disabled channels: their ready/wait/wr/rd are ignored, and their ch_valid is 0.
- Changing ch_en mid-transaction takes effect the same cycle. A channel disabled while claimed stops contributing to wait; the watchdog still runs if claimed was already set.
- Sticky flags:
  - set-dominant: a set event in the same cycle as status_clr leaves the flag set
  - cleared only by status_clr or reset
- A ready in the same cycle as a watchdog expiry: ready wins and err_timeout is not set.
- Reset asserted mid-transaction returns to IDLE immediately (async); outputs are cleared.

Decomposition:
- Shared package pcpi_pkg:
  - state enum (IDLE, ACTIVE, RESP, DRAIN)
  - default XLEN, WDOG_LIMIT, and the CH_W clog2 helper
- One sub-module, pcpi_prio_sel: lowest-index one-hot/encoder plus the multi-hot detect. Parameter N_CH; outputs idx, any, multi.
- The core wrapper instantiates pcpi_hub with N_CH=4 in place of the OR/priority mux.

Test Plan:
1. ch_en=4'b1111, insn issued, ch2 wait 5 cycles then ready with wr=1, rd=32'hDEAD_BEEF:
   - core sees pcpi_ready one cycle later with rd=DEADBEEF, wr=1; last_ch=2
   - ch_valid=0 from the RESP cycle onward
2. ch0 and ch3 ready in the same cycle (rd=0x11 / 0x33):
   - rd=0x11, last_ch=0, err_collision=1
   - status_clr → flag 0
3. ch_en=4'b1011, ch2 asserts wait/ready:
   - ignored; pcpi_wait=0
   - core drops valid after 16 cycles → busy=0, no pcpi_ready
4. WDOG_LIMIT=20; ch1 waits forever:
   - pcpi_ready with wr=0, rd=0 exactly 20 cycles after the first claim
   - err_timeout=1
5. Core holds pcpi_valid for 3 cycles after RESP:
   - FSM stays in DRAIN; ch_valid=0; no second ready
   - valid low → IDLE next cycle
6. reset pulsed during ACTIVE with ch1 waiting:
   - all outputs 0, busy=0 immediately
   - a subsequent op completes normally
